// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle fetch/decode/execute sequencer for the 4-bit CPU.
// Holds the PC, instruction register, 4x4-bit register file and the Z/N flags.
// It drives a combinational ALU and performs writeback, branch resolution and stores.
// Optional feature: define CPU_CU_HALT_EN so that instruction 0x0F halts the core until reset.
module cpu_control_unit #(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [7:0]      imem_rdata,
  output logic [3:0]      alu_op,
  output logic [3:0]      alu_rx,
  output logic [3:0]      alu_ry,
  output logic [3:0]      alu_mem,
  input  logic [3:0]      alu_out,
  input  logic            alu_z,
  input  logic            alu_n,
  output logic [3:0]      dmem_addr,
  output logic            dmem_we,
  output logic [3:0]      dmem_wdata,
  input  logic [3:0]      dmem_rdata,
  output logic [PC_W-1:0] pc,
  output logic            flag_z,
  output logic            flag_n,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
`ifdef CPU_CU_HALT_EN
    S_MEM,
    S_HALT
`else
    S_MEM
`endif
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
    OP_OR  = 4'h4, OP_XOR = 4'h5, OP_NOT = 4'h6, OP_LSL = 4'h7,
    OP_LSR = 4'h8, OP_JMP = 4'h9, OP_JZ  = 4'hA, OP_JNZ = 4'hB,
    OP_JN  = 4'hC, OP_JNN = 4'hD, OP_LD  = 4'hE, OP_ST  = 4'hF
  } op_t;

  state_t          state, state_next;
  logic [7:0]      ir;
  logic [3:0]      regs [4];
  logic [PC_W-1:0] pc_next;
  logic            ir_load;
  logic            reg_we;
  logic            flag_we;

  op_t             opcode;
  logic [1:0]      rx_idx;
  logic [1:0]      ry_idx;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] jump_target;

  assign opcode      = op_t'(ir[7:4]);
  assign rx_idx      = ir[3:2];
  assign ry_idx      = ir[1:0];
  assign pc_inc      = pc + PC_W'(1);
  assign jump_target = PC_W'(alu_out);

  // Datapath taps: operands come straight from the register file, the store data from the ALU.
  assign imem_addr  = pc;
  assign alu_rx     = regs[rx_idx];
  assign alu_ry     = regs[ry_idx];
  assign alu_mem    = dmem_rdata;
  assign dmem_addr  = regs[ry_idx];
  assign dmem_wdata = alu_out;

`ifdef CPU_CU_HALT_EN
  assign halted = (state == S_HALT);
`else
  assign halted = 1'b0;
`endif

  // Next-state, next-pc and write-enable decode for the sequencer.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    pc_next    = pc;
    ir_load    = 1'b0;
    reg_we     = 1'b0;
    flag_we    = 1'b0;
    alu_op     = 4'h0;
    dmem_we    = 1'b0;

    case (state)
      S_FETCH: begin
        if (en) state_next = S_DECODE;
      end

      S_DECODE: begin
        if (en) begin
          ir_load    = 1'b1;
          state_next = S_EXEC;
        end
      end

      S_EXEC: begin
        alu_op = ir[7:4];
        if (en) begin
          state_next = S_FETCH;
          case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LSL, OP_LSR: begin
              reg_we  = 1'b1;
              flag_we = 1'b1;
              pc_next = pc_inc;
            end
            OP_NOP: begin
`ifdef CPU_CU_HALT_EN
              if (ir == 8'h0F) state_next = S_HALT;
              else             pc_next    = pc_inc;
`else
              pc_next = pc_inc;
`endif
            end
            OP_JMP: pc_next = jump_target;
            OP_JZ:  pc_next = flag_z  ? jump_target : pc_inc;
            OP_JNZ: pc_next = !flag_z ? jump_target : pc_inc;
            OP_JN:  pc_next = flag_n  ? jump_target : pc_inc;
            OP_JNN: pc_next = !flag_n ? jump_target : pc_inc;
            OP_LD:  state_next = S_MEM;
            OP_ST: begin
              dmem_we = 1'b1;
              pc_next = pc_inc;
            end
            default: state_next = S_FETCH;
          endcase
        end
      end

      S_MEM: begin
        alu_op = OP_LD;
        if (en) begin
          reg_we     = 1'b1;
          flag_we    = 1'b1;
          pc_next    = pc_inc;
          state_next = S_FETCH;
        end
      end

`ifdef CPU_CU_HALT_EN
      S_HALT: state_next = S_HALT;
`endif

      default: state_next = S_FETCH;
    endcase

    // A reset edge must never coincide with a store.
    if (rst) dmem_we = 1'b0;
  end

  // Architectural state: state register, pc, ir, register file and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_FETCH;
      pc     <= '0;
      ir     <= 8'h00;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      // NOTE: the register file is architecturally visible after reset, so it is cleared here
      // rather than left to power-up contents.
      for (int i = 0; i < 4; i++) regs[i] <= 4'h0;
    end else begin
      // NOTE: all state updates here are non-blocking so every register samples pre-edge values.
      state <= state_next;
      pc    <= pc_next;
      if (ir_load) ir <= imem_rdata;
      if (reg_we)  regs[rx_idx] <= alu_out;
      if (flag_we) begin
        flag_z <= alu_z;
        flag_n <= alu_n;
      end
    end
  end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 4-bit CPU.
- Owns the PC, instruction register, 4x4-bit register file and latched Z/N flags.
- Drives the ALU's op/rx/ry/mem inputs and consumes its out/z/n results.
- Sits between instruction memory, data memory and the combinational ALU, and performs writeback, branch resolution and stores.

Parameters:
PC_W, 4, program counter / instruction address width (>=4); 4-bit jump targets are zero-extended.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
en  in  1  run enable; low freezes all state
imem_addr  out  PC_W  instruction fetch address (= pc)
imem_rdata  in  8  instruction word, valid the cycle after imem_addr is presented
alu_op  out  4  ALU opcode
alu_rx  out  4  ALU operand rx (reg[rx_idx])
alu_ry  out  4  ALU operand ry (reg[ry_idx])
alu_mem  out  4  ALU load-data input (= dmem_rdata)
alu_out  in  4  ALU result
alu_z  in  1  ALU zero flag
alu_n  in  1  ALU negative flag
dmem_addr  out  4  data memory address (= reg[ry_idx])
dmem_we  out  1  data memory write strobe
dmem_wdata  out  4  store data (= alu_out)
dmem_rdata  in  4  data memory read data, synchronous, 1-cycle latency
pc  out  PC_W  current program counter
flag_z  out  1  latched zero flag
flag_n  out  1  latched negative flag
halted  out  1  halt indicator (see Optional Feature)

Behaviour:
- Clock and reset: one clock `clk`; synchronous active-high reset `rst`.
- Instruction format: ir[7:4] opcode, ir[3:2] rx_idx, ir[1:0] ry_idx.
- Opcode map: 0 nop, 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 not, 7 lsl, 8 lsr, 9 jmp, A jz, B jnz, C jn, D jnn, E ld, F st.
- Reset: pc=0, ir=0x00, all regs=0, flag_z=0, flag_n=0, state=FETCH, halted=0. dmem_we=0 and alu_op=0 whenever not in EXEC/MEM.
- FSM states: FETCH -> DECODE -> EXEC -> (MEM if ld) -> FETCH. All transitions are gated by en.
- FETCH: imem_addr=pc. Next DECODE.
- DECODE: ir <= imem_rdata at the end of the cycle. Next EXEC.
- EXEC:
  - alu_op=ir[7:4], alu_rx=reg[rx_idx], alu_ry=reg[ry_idx], dmem_addr=reg[ry_idx].
  - Ops 1-8: reg[rx_idx] <= alu_out; flag_z <= alu_z; flag_n <= alu_n; pc <= pc+1.
  - nop: pc <= pc+1 only.
  - jmp: pc <= alu_out, always.
  - jz / jnz / jn / jnn: taken when flag_z / !flag_z / flag_n / !flag_n respectively. Taken: pc <= alu_out. Not taken: pc <= pc+1. Flags are not modified.
  - st: dmem_we=1 for exactly this cycle, dmem_wdata=alu_out; pc <= pc+1; flags unchanged.
  - ld: no write this cycle; next state MEM.
  - All other opcodes: next state FETCH.
- MEM (ld only):
  - alu_op=0xE, alu_mem=dmem_rdata.
  - reg[rx_idx] <= alu_out; flag_z/flag_n <= alu_z/alu_n; pc <= pc+1. Next FETCH.
- Latency: 3 cycles per instruction; ld takes 4.
- pc arithmetic: pc+1 wraps modulo 2^PC_W. Jump targets are zero-extended to PC_W.
- rx_idx == ry_idx is legal: operands are read before the write; the write lands at the clock edge.
- en low:
  - State, pc, ir, regs and flags hold.
  - dmem_we forced 0; combinational outputs still reflect the current state.
  - Deasserting en in EXEC suppresses the store until en returns. The store then issues exactly once.
- rst asserted in any state, including mid-ld: full reset on that edge; no writeback and no store occur that cycle.

Optional Feature:
- Macro: CPU_CU_HALT_EN.
- When defined:
  - Instruction 0x0F (nop with rx_idx=ry_idx=3) in EXEC sets halted=1 and leaves pc unchanged.
  - FSM enters HALT and stays there, ignoring en, until rst.
  - In HALT, dmem_we=0 and alu_op=0.
- When undefined: 0x0F executes as an ordinary nop (pc+1), halted is tied to 0 and the HALT state does not exist.

Test Plan:
1. Reset, en=1, imem[0]=0x00 -> pc reads 0,0,0,1 at FETCH boundaries (3-cycle cadence); flags stay 0; dmem_we never asserted.
2. dmem[0]=5; program 0xE1 (ld r0,[r1]), 0x10 (add r0,r0) -> the ld takes 4 cycles and r0=5; after the add, r0=0xA, flag_n=1, flag_z=0, pc=2.
3. Continue with 0x20 (sub r0,r0), 0xA4 (jz r1, r1=0) -> r0=0, flag_z=1; the jump is taken and pc=0. Repeat with 0xB4 (jnz) -> not taken, pc=4.
4. r0=0xA, r1=3; instruction 0xF1 (st r0,[r1]) -> dmem_we high for exactly 1 cycle with dmem_addr=3 and dmem_wdata=0xA; flags unchanged.
5. Drop en for 5 cycles during EXEC of a st, then raise it -> exactly one dmem_we pulse after en returns; pc and regs frozen meanwhile. Assert rst during the MEM cycle of a ld -> rx_idx register stays 0 and pc=0.
6. With CPU_CU_HALT_EN: 0x0F at pc=2 -> halted=1, pc stays 2 indefinitely, en toggling has no effect, rst clears it. Without the macro: pc advances to 3 and halted stays 0.
